// File: rtl/fifo_uart_tx.sv
// Pops bytes from the upstream FIFO and serialises them as UART frames on tx.
// Start bit begins 3 cycles after enable & !fifo_empty in IDLE; the read is held off while a FIFO write collides.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b0,
  parameter bit PARITY_ODD   = 1'b0,
  parameter int STOP_BITS    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        fifo_empty,
  input  logic        fifo_full,
  input  logic        fifo_wr_mon,
  input  logic [7:0]  fifo_dout,
  output logic        fifo_rd,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic [15:0] frame_cnt
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX  = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, PARITY, STOP} state_t;

  state_t        state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0]    bitc, bitc_n;
  logic [7:0]    shreg, shreg_n;
  logic          par, par_n;
  logic          tx_n;
  logic          bit_end;

  assign bit_end = (baud == BAUD_MAX);
  assign busy    = (state != IDLE);
  // A non-full write owns the FIFO port this cycle, so the pop waits.
  assign fifo_rd = (state == FETCH) && !(fifo_wr_mon && !fifo_full);

  always_comb begin
    state_n = state;
    bitc_n  = bitc;
    shreg_n = shreg;
    par_n   = par;
    done    = 1'b0;
    case (state)
      IDLE:   if (enable && !fifo_empty) state_n = FETCH;
      FETCH:  if (fifo_rd) state_n = LOAD;
      LOAD: begin
        shreg_n = fifo_dout;
        par_n   = (^fifo_dout) ^ PARITY_ODD;
        state_n = START;
      end
      START:  if (bit_end) state_n = DATA;
      DATA: begin
        if (bit_end) begin
          shreg_n = {1'b0, shreg[7:1]};
          bitc_n  = bitc + 3'd1;
          if (bitc == 3'd7) state_n = PARITY_EN ? PARITY : STOP;
        end
      end
      PARITY: if (bit_end) state_n = STOP;
      STOP: begin
        if (bit_end) begin
          if (bitc == LAST_STOP) begin
            done    = 1'b1;
            bitc_n  = 3'd0;
            state_n = IDLE;
          end else begin
            bitc_n = bitc + 3'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (state_n != state || bit_end) baud_n = '0;
    else                             baud_n = baud + 1'b1;

    // tx is computed from the next state so the line changes exactly on state entry.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[0];
      PARITY:  tx_n = par_n;
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      baud      <= '0;
      bitc      <= 3'd0;
      shreg     <= 8'd0;
      par       <= 1'b0;
      tx        <= 1'b1;
      frame_cnt <= 16'd0;
    end else begin
      state <= state_n;
      baud  <= baud_n;
      bitc  <= bitc_n;
      shreg <= shreg_n;
      par   <= par_n;
      tx    <= tx_n;
      if (done) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule
